pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
// - Pipeline sequencer for the 5-stage core. Merges the ID load-use stall request with EX multi-cycle ops
//   (madd/msub 2-cycle accumulate, iterative divide), producing the per-stage stall vector.
// - Drives the divider start handshake and the madd cycle index consumed by EX.
// - Sits beside ID/EX; stall_o fans out to pc_reg, if_id, id_ex, ex_mem, mem_wb.
// PARAMETERS
// - STALL_W      6    stall vector width: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
// - DIV_TIMEOUT  40   max DIV_WAIT cycles before watchdog abort
// - CNT_W        6    watchdog counter width; must hold DIV_TIMEOUT
// PORTS
// - clk          in   1        rising-edge clock
// - rst          in   1        reset, synchronous, active-high
// - flush_i      in   1        exception flush; abort any multi-cycle op
// - id_stallreq  in   1        load-use hazard from ID (combinational)
// - ex_mc_valid  in   1        EX holds a multi-cycle instruction
// - ex_mc_op     in   2        0 none, 1 madd/msub, 2 div/divu, 3 reserved (treated as none)
// - div_ready_i  in   1        divider result valid (1-cycle pulse or level)
// - stall_o      out  STALL_W  per-stage hold
// - div_start_o  out  1        divider run request, level
// - mc_cnt_o     out  2        madd cycle index: 0 first, 1 second
// - busy_o       out  1        FSM not IDLE
// - timeout_o    out  1        1-cycle pulse on divider watchdog abort
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE, watchdog=0. Outputs: stall_o=0, div_start_o=0, mc_cnt_o=0,
//   busy_o=0, timeout_o=0. Reset mid-op discards the op; no divider handshake survives.
// - States: IDLE, MADD1, DIV_WAIT, DIV_DONE. Outputs decode combinationally from state + inputs.
// - ex_stall (6'b001111) vs id_stall (6'b000111): ex_stall wins when both; neither -> 0.
// - IDLE:
//   - ex_mc_valid & op=1: ex_stall, mc_cnt_o=0, next MADD1.
//   - ex_mc_valid & op=2: ex_stall, next DIV_WAIT, watchdog<=0.
//   - Otherwise: stall_o = id_stallreq ? id_stall : 0.
// - MADD1:
//   - mc_cnt_o=1, no ex_stall, id_stall honoured, next IDLE unconditionally.
//   - ex_mc_valid still high here is the same instruction; it must not retrigger.
// - DIV_WAIT:
//   - div_start_o=1, ex_stall, watchdog+1 each cycle.
//   - div_ready_i=1 -> next DIV_DONE (ex_stall still held this cycle).
//   - watchdog==DIV_TIMEOUT-1 & !div_ready_i -> timeout_o=1 this cycle, next DIV_DONE.
//   - Ready and timeout in the same cycle: ready wins, timeout_o=0.
// - DIV_DONE:
//   - div_start_o=0, no ex_stall (EX consumes result), id_stall honoured, next IDLE.
// - flush_i=1 (any state): stall_o=0, div_start_o=0, timeout_o=0 this cycle; next IDLE, watchdog=0.
//   Flush overrides rst only in the sense that rst also yields IDLE.
// - busy_o = (state != IDLE). Latency: madd 1 stall cycle; div = N+1 stall cycles,
//   N = cycles until div_ready_i.
// STRUCTURE
// - Stall codes, ex_mc_op encodings, and state encodings are added to defines.v
//   (shared by ex, ctrl, and the bench).
// - One sub-module: div_watchdog (CNT_W counter with clear/enable/terminal-count).
//   FSM + output decode stay in the top.
// TESTING
// - Reset: hold rst 2 cycles with ex_mc_valid=1 op=2 -> stall_o=0, div_start_o=0, busy_o=0.
// - id_stallreq=1, ex_mc_valid=0 -> stall_o=6'b000111 same cycle. Release -> 0.
// - madd: ex_mc_valid=1 op=1 -> cycle0 stall_o=001111 mc_cnt_o=0; cycle1 stall_o=0 mc_cnt_o=1;
//   cycle2 IDLE. Back-to-back madd repeats the pattern.
// - div: op=2, div_ready_i at 5th DIV_WAIT cycle -> 6 cycles stall_o=001111, div_start_o high 5 cycles;
//   DIV_DONE with stall_o=0. Also with id_stallreq=1 in DIV_WAIT -> 001111; in DIV_DONE -> 000111.
// - Watchdog: div_ready_i never -> timeout_o pulse on DIV_WAIT cycle 40, then DIV_DONE, IDLE.
//   Repeat with ready on cycle 40 -> no timeout_o.
// - flush_i in DIV_WAIT cycle 3 -> same-cycle stall_o=0, div_start_o=0; next cycle IDLE.
//   Repeat with rst instead -> identical end state.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall sequencer: stall codes,
// EX multi-cycle op encodings, FSM state encoding, and a small helper
// that selects the ID load-use stall code.
package pipe_stall_ctrl_pkg;

   localparam int STALL_W     = 6;
   localparam int DIV_TIMEOUT = 40;
   localparam int CNT_W       = 6;

   // stall bit order: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_MADD = 2'd1,
      OP_DIV  = 2'd2,
      OP_RSVD = 2'd3
   } mc_op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MADD1    = 2'd1,
      ST_DIV_WAIT = 2'd2,
      ST_DIV_DONE = 2'd3
   } state_e;

   function automatic logic [5:0] id_stall_sel(input logic req);
      return req ? STALL_ID : STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_watchdog.sv
// Divider watchdog: counts DIV_WAIT cycles and flags the terminal count.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear (entry into DIV_WAIT, flush)
//   en   - count enable (one increment per DIV_WAIT cycle)
//   tc   - count has reached TERM-1 (last allowed wait cycle)
module pipe_stall_ctrl_div_watchdog #(
   parameter int CNT_W = 6,
   parameter int TERM  = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == CNT_W'(TERM - 1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer for the 5-stage core. Merges the ID load-use
// stall request with EX multi-cycle ops (2-cycle madd/msub, iterative
// divide) into the per-stage stall vector, drives the divider start
// handshake and the madd cycle index.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-high reset
//   flush_i      - exception flush, aborts any multi-cycle op
//   id_stallreq  - load-use hazard from ID
//   ex_mc_valid  - EX holds a multi-cycle instruction
//   ex_mc_op     - 0 none, 1 madd/msub, 2 div/divu, 3 reserved (none)
//   div_ready_i  - divider result valid
//   stall_o      - per-stage hold (bit0 pc .. bit5 wb)
//   div_start_o  - divider run request, level
//   mc_cnt_o     - madd cycle index (0 first, 1 second)
//   busy_o       - sequencer not idle
//   timeout_o    - one-cycle pulse on divider watchdog abort
//
// state       | meaning
// ST_IDLE     | no multi-cycle op in flight; ID stall passes through
// ST_MADD1    | second madd cycle; EX free, ID stall honoured
// ST_DIV_WAIT | divider running; EX and upstream held
// ST_DIV_DONE | result consumed by EX; ID stall honoured
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int STALL_W     = pipe_stall_ctrl_pkg::STALL_W,
   parameter int DIV_TIMEOUT = pipe_stall_ctrl_pkg::DIV_TIMEOUT,
   parameter int CNT_W       = pipe_stall_ctrl_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               id_stallreq,
   input  logic               ex_mc_valid,
   input  logic [1:0]         ex_mc_op,
   input  logic               div_ready_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               div_start_o,
   output logic [1:0]         mc_cnt_o,
   output logic               busy_o,
   output logic               timeout_o
);

   state_e state;
   state_e state_nxt;
   logic   wd_clr;
   logic   wd_en;
   logic   wd_tc;

   logic [STALL_W-1:0] stall_ex;
   logic [STALL_W-1:0] stall_id;

   assign stall_ex = STALL_W'(STALL_EX);
   assign stall_id = STALL_W'(id_stall_sel(id_stallreq));

   pipe_stall_ctrl_div_watchdog #(
      .CNT_W (CNT_W),
      .TERM  (DIV_TIMEOUT)
   ) u_div_watchdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .en  (wd_en),
      .tc  (wd_tc)
   );

   always_comb begin
      state_nxt   = state;
      stall_o     = '0;
      div_start_o = 1'b0;
      mc_cnt_o    = 2'd0;
      timeout_o   = 1'b0;
      wd_clr      = 1'b0;
      wd_en       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (ex_mc_valid && (ex_mc_op == OP_MADD)) begin
               stall_o   = stall_ex;
               state_nxt = ST_MADD1;
            end else if (ex_mc_valid && (ex_mc_op == OP_DIV)) begin
               stall_o   = stall_ex;
               state_nxt = ST_DIV_WAIT;
               wd_clr    = 1'b1;
            end else begin
               stall_o = stall_id;
            end
         end
         // ex_mc_valid still high here belongs to the same madd; ignore it
         ST_MADD1: begin
            mc_cnt_o  = 2'd1;
            stall_o   = stall_id;
            state_nxt = ST_IDLE;
         end
         ST_DIV_WAIT: begin
            div_start_o = 1'b1;
            stall_o     = stall_ex;
            wd_en       = 1'b1;
            // a ready arriving on the last allowed cycle suppresses the abort
            if (div_ready_i) begin
               state_nxt = ST_DIV_DONE;
            end else if (wd_tc) begin
               timeout_o = 1'b1;
               state_nxt = ST_DIV_DONE;
            end
         end
         ST_DIV_DONE: begin
            stall_o   = stall_id;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (flush_i) begin
         stall_o     = '0;
         div_start_o = 1'b0;
         timeout_o   = 1'b0;
         state_nxt   = ST_IDLE;
         wd_clr      = 1'b1;
         wd_en       = 1'b0;
      end

      // reset silences every output, including a request already on the inputs
      if (rst) begin
         stall_o     = '0;
         div_start_o = 1'b0;
         mc_cnt_o    = 2'd0;
         timeout_o   = 1'b0;
         state_nxt   = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign busy_o = !rst && (state != ST_IDLE);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush_i;
   logic       id_stallreq;
   logic       ex_mc_valid;
   logic [1:0] ex_mc_op;
   logic       div_ready_i;
   logic [5:0] stall_o;
   logic       div_start_o;
   logic [1:0] mc_cnt_o;
   logic       busy_o;
   logic       timeout_o;

   int checks = 0;
   int errors = 0;

   // reference model: second-madd flag, completed divider wait cycles
   // (-1 when no divide is waiting), result-consume flag
   bit m_madd2 = 1'b0;
   bit m_done  = 1'b0;
   int m_wait  = -1;

   int n_ex    = 0;
   int n_start = 0;
   int n_to    = 0;

   pipe_stall_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .id_stallreq (id_stallreq),
      .ex_mc_valid (ex_mc_valid),
      .ex_mc_op    (ex_mc_op),
      .div_ready_i (div_ready_i),
      .stall_o     (stall_o),
      .div_start_o (div_start_o),
      .mc_cnt_o    (mc_cnt_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit f, input bit id, input bit v,
                      input logic [1:0] op, input bit rdy);
      logic [5:0] e_stall;
      logic [1:0] e_mc;
      bit e_start, e_to, e_busy, is_madd, is_div;
      @(negedge clk);
      rst = r; flush_i = f; id_stallreq = id; ex_mc_valid = v;
      ex_mc_op = op; div_ready_i = rdy;
      #1;
      is_madd = v && (op == 2'd1);
      is_div  = v && (op == 2'd2);
      e_stall = 6'b000000; e_start = 1'b0; e_to = 1'b0;
      e_mc    = m_madd2 ? 2'd1 : 2'd0;
      e_busy  = m_madd2 || m_done || (m_wait >= 0);
      if (m_madd2 || m_done) begin
         e_stall = id ? 6'b000111 : 6'b000000;
      end else if (m_wait >= 0) begin
         e_stall = 6'b001111;
         e_start = 1'b1;
         e_to    = (m_wait == TO - 1) && !rdy;
      end else begin
         e_stall = (is_madd || is_div) ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
      end
      if (f) begin
         e_stall = 6'b000000; e_start = 1'b0; e_to = 1'b0;
      end
      if (r) begin
         e_stall = 6'b000000; e_start = 1'b0; e_to = 1'b0; e_mc = 2'd0; e_busy = 1'b0;
      end
      chk("stall_o", {2'b00, stall_o}, {2'b00, e_stall});
      chk("div_start_o", {7'd0, div_start_o}, {7'd0, e_start});
      chk("mc_cnt_o", {6'd0, mc_cnt_o}, {6'd0, e_mc});
      chk("busy_o", {7'd0, busy_o}, {7'd0, e_busy});
      chk("timeout_o", {7'd0, timeout_o}, {7'd0, e_to});
      if (stall_o == 6'b001111) n_ex++;
      if (div_start_o) n_start++;
      if (timeout_o) n_to++;
      @(posedge clk);
      if (r || f) begin
         m_madd2 = 1'b0; m_done = 1'b0; m_wait = -1;
      end else if (m_madd2) begin
         m_madd2 = 1'b0;
      end else if (m_wait >= 0) begin
         if (rdy || (m_wait == TO - 1)) begin
            m_wait = -1; m_done = 1'b1;
         end else begin
            m_wait++;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (is_madd) begin
         m_madd2 = 1'b1;
      end else if (is_div) begin
         m_wait = 0;
      end
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; id_stallreq = 1'b0;
      ex_mc_valid = 1'b1; ex_mc_op = 2'd2; div_ready_i = 1'b0;

      // reset held with a divide request on the inputs
      cyc(1, 0, 0, 1, 2'd2, 0);
      cyc(1, 0, 0, 1, 2'd2, 0);

      // load-use stall alone, then released; reserved op behaves as none
      cyc(0, 0, 1, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 1, 1, 2'd3, 0);

      // single madd (valid held into second cycle), then back-to-back
      cyc(0, 0, 0, 1, 2'd1, 0);
      cyc(0, 0, 0, 1, 2'd1, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2'd1, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // divide, ready on the 5th wait cycle
      n_ex = 0; n_start = 0;
      cyc(0, 0, 0, 1, 2'd2, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 1, 2'd2, 1);
      chk("div_stall_cycles", 8'(n_ex), 8'd6);
      chk("div_start_cycles", 8'(n_start), 8'd5);
      cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // divide with load-use stall pending throughout
      cyc(0, 0, 1, 1, 2'd2, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 2'd2, 0);
      cyc(0, 0, 1, 0, 2'd0, 1);
      cyc(0, 0, 1, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // watchdog abort: no ready ever
      n_to = 0;
      cyc(0, 0, 0, 1, 2'd2, 0);
      for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 2'd0, 0);
      chk("timeout_pulses", 8'(n_to), 8'd1);
      cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // ready on the last allowed cycle: no abort
      n_to = 0;
      cyc(0, 0, 0, 1, 2'd2, 0);
      for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 1);
      chk("timeout_suppressed", 8'(n_to), 8'd0);
      cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // flush on 3rd wait cycle, then the same with reset
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 1, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 1, 2'd2, 0);
      cyc(1, 0, 0, 1, 2'd2, 0);
      cyc(0, 0, 0, 0, 2'd0, 0);

      // random traffic, frequent then rare divider ready
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
             1'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(0, 7) == 0);
      end
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 255) == 0, $urandom_range(0, 127) == 0,
             1'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(0, 59) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
